// File: rtl/ysyx_pkg.sv
// Shared decode constants, FSM state and immediate-format types for the
// ysyx multi-cycle RV32I/E core.
package ysyx_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U, IMM_J} imm_e;

   localparam logic [6:0] OP_IMM   = 7'b001_0011;
   localparam logic [6:0] OP_REG   = 7'b011_0011;
   localparam logic [6:0] OP_LUI   = 7'b011_0111;
   localparam logic [6:0] OP_AUIPC = 7'b001_0111;
   localparam logic [6:0] OP_JAL   = 7'b110_1111;
   localparam logic [6:0] OP_JALR  = 7'b110_0111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [6:0] F7_ADD = 7'b000_0000;
   localparam logic [6:0] F7_SUB = 7'b010_0000;

   localparam logic [XLEN-1:0]   INST_EBREAK = 32'h0010_0073;
   localparam logic [REG_AW-1:0] REG_A0      = 5'd10;

   // Sign-extended immediate for the given instruction format.
   function automatic logic [XLEN-1:0] imm_gen(input logic [XLEN-1:0] w, input imm_e sel);
      logic [XLEN-1:0] imm;
      imm = '0;
      case (sel)
         IMM_I:   imm = {{20{w[31]}}, w[31:20]};
         IMM_U:   imm = {w[31:12], 12'h000};
         IMM_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/ysyx_regfile.sv
// Integer register file: two combinational read ports, one synchronous write
// port; x0 and out-of-range indices read as zero and ignore writes.
module ysyx_regfile
   import ysyx_pkg::*;
#(
   parameter int unsigned NR_REGS = 32
) (
   input  logic                clk,
   input  logic [REG_AW-1:0]   raddr1,
   output logic [XLEN-1:0]     rdata1,
   input  logic [REG_AW-1:0]   raddr2,
   output logic [XLEN-1:0]     rdata2,
   input  logic                we,
   input  logic [REG_AW-1:0]   waddr,
   input  logic [XLEN-1:0]     wdata
);

   localparam int unsigned AW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

   logic [XLEN-1:0] regs [NR_REGS];

   function automatic logic live(input logic [REG_AW-1:0] a);
      return (a != '0) && (32'(a) < NR_REGS);
   endfunction

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (live(raddr1)) rdata1 = regs[raddr1[AW-1:0]];
      if (live(raddr2)) rdata2 = regs[raddr2[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (we && live(waddr)) regs[waddr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ysyx_mc_core.sv
// Multi-cycle RV32I/E subset core (addi/add/sub/lui/auipc/jal/jalr/ebreak):
// FETCH waits for the instruction word, EXEC retires it in one cycle.
module ysyx_mc_core
   import ysyx_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned NR_REGS  = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req_valid,
   output logic [31:0] pc,
   input  logic        inst_resp_valid,
   input  logic [31:0] inst,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic        halt,
   output logic        halt_illegal,
   output logic [31:0] halt_code
);

   state_e          state, state_nx;
   logic [XLEN-1:0] inst_q;

   logic [6:0]        opcode, funct7;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd, rs1, rs2, raddr1;
   logic              legal, is_ebreak, rd_we, use_rs1, use_rs2, regs_ok, illegal, halt_req, rf_we;
   imm_e              imm_sel;
   logic [XLEN-1:0]   imm, rs1_val, rs2_val, result, pc_nx, pc_plus4, jalr_sum;

   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign funct3 = inst_q[14:12];
   assign rs1    = inst_q[19:15];
   assign rs2    = inst_q[24:20];
   assign funct7 = inst_q[31:25];

   // Decode: legality, register usage and immediate format.
   always_comb begin
      legal     = 1'b0;
      is_ebreak = 1'b0;
      rd_we     = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      imm_sel   = IMM_NONE;
      case (opcode)
         OP_IMM: if (funct3 == F3_ADD) begin
            legal = 1'b1; rd_we = 1'b1; use_rs1 = 1'b1; imm_sel = IMM_I;
         end
         OP_REG: if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
            legal = 1'b1; rd_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            legal = 1'b1; rd_we = 1'b1; imm_sel = IMM_U;
         end
         OP_JAL: begin
            legal = 1'b1; rd_we = 1'b1; imm_sel = IMM_J;
         end
         OP_JALR: if (funct3 == F3_ADD) begin
            legal = 1'b1; rd_we = 1'b1; use_rs1 = 1'b1; imm_sel = IMM_I;
         end
         default: if (inst_q == INST_EBREAK) begin
            legal = 1'b1; is_ebreak = 1'b1;
         end
      endcase
      regs_ok = (!rd_we   || 32'(rd)  < NR_REGS) &&
                (!use_rs1 || 32'(rs1) < NR_REGS) &&
                (!use_rs2 || 32'(rs2) < NR_REGS);
      illegal  = !(legal && regs_ok);
      halt_req = illegal || is_ebreak;
   end

   // Halting instructions read a0 through port 1 so halt_code needs no extra port.
   assign raddr1 = halt_req ? REG_A0 : rs1;
   assign rf_we  = (state == S_EXEC) && !halt_req && rd_we && !rst;

   ysyx_regfile #(.NR_REGS(NR_REGS)) u_regfile (
      .clk    (clk),
      .raddr1 (raddr1),
      .rdata1 (rs1_val),
      .raddr2 (rs2),
      .rdata2 (rs2_val),
      .we     (rf_we),
      .waddr  (rd),
      .wdata  (result)
   );

   // Execute: writeback value and next PC.
   always_comb begin
      imm      = imm_gen(inst_q, imm_sel);
      pc_plus4 = pc + 32'd4;
      jalr_sum = rs1_val + imm;
      result   = '0;
      pc_nx    = pc_plus4;
      case (opcode)
         OP_IMM:   result = rs1_val + imm;
         OP_REG:   result = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
         OP_LUI:   result = imm;
         OP_AUIPC: result = pc + imm;
         OP_JAL: begin
            result = pc_plus4;
            pc_nx  = pc + imm;
         end
         OP_JALR: begin
            result = pc_plus4;
            pc_nx  = {jalr_sum[31:1], 1'b0};
         end
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = S_FETCH;
         S_FETCH: if (inst_resp_valid) state_nx = S_EXEC;
         S_EXEC:  state_nx = halt_req ? S_HALT : S_FETCH;
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      inst_req_valid = 1'b0;
      commit_valid   = 1'b0;
      commit_pc      = pc;
      if (!rst) begin
         inst_req_valid = (state == S_FETCH);
         commit_valid   = (state == S_EXEC) && !halt_req;
      end
   end

   // PC, fetched word and sticky halt status.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         inst_q       <= '0;
         halt         <= 1'b0;
         halt_illegal <= 1'b0;
         halt_code    <= '0;
      end else begin
         if (state == S_FETCH && inst_resp_valid) inst_q <= inst;
         if (state == S_EXEC) begin
            if (illegal) begin
               halt         <= 1'b1;
               halt_illegal <= 1'b1;
               halt_code    <= rs1_val;
            end else begin
               pc <= pc_nx;
               if (is_ebreak) begin
                  halt      <= 1'b1;
                  halt_code <= rs1_val;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_mc_core.sv
// Directed bench for ysyx_mc_core: expected commit PCs are queued as each
// instruction is served and popped when the core pulses commit_valid.
module tb_ysyx_mc_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_valid, inst_resp_valid, commit_valid, halt, halt_illegal;
   logic [31:0] pc, inst, commit_pc, halt_code;

   logic        inst_req_valid_e, inst_resp_valid_e, commit_valid_e, halt_e, halt_illegal_e;
   logic [31:0] pc_e, inst_e, commit_pc_e, halt_code_e;

   int          n_checks = 0;
   int          n_err    = 0;
   int          n_commits = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   ysyx_mc_core dut (
      .clk(clk), .rst(rst), .inst_req_valid(inst_req_valid), .pc(pc),
      .inst_resp_valid(inst_resp_valid), .inst(inst), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .halt(halt), .halt_illegal(halt_illegal), .halt_code(halt_code)
   );

   ysyx_mc_core #(.RESET_PC(32'h8000_0000), .NR_REGS(16)) dut_e (
      .clk(clk), .rst(rst), .inst_req_valid(inst_req_valid_e), .pc(pc_e),
      .inst_resp_valid(inst_resp_valid_e), .inst(inst_e), .commit_valid(commit_valid_e),
      .commit_pc(commit_pc_e), .halt(halt_e), .halt_illegal(halt_illegal_e), .halt_code(halt_code_e)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Commit monitor: every pulse must match the oldest queued PC.
   always @(negedge clk) begin
      if (commit_valid === 1'b1) begin
         n_commits++;
         if (exp_q.size() == 0) chk("commit_spurious", 32'(commit_valid), 32'd0);
         else                   chk("commit_pc", commit_pc, exp_q.pop_front());
      end
   end

   // Serve one instruction at the expected fetch PC, optionally stalling the response.
   task automatic issue(input logic [31:0] w, input logic [31:0] exp_pc, input int delay, input bit commits);
      bit ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (inst_req_valid === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      chk("fetch_req", 32'(ok), 32'd1);
      chk("fetch_pc", pc, exp_pc);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("hold_req", 32'(inst_req_valid), 32'd1);
         chk("hold_pc", pc, exp_pc);
      end
      if (commits) exp_q.push_back(exp_pc);
      inst_resp_valid = 1'b1;
      inst            = w;
      @(negedge clk);
      inst_resp_valid = 1'b0;
      inst            = $urandom();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req", 32'(inst_req_valid), 32'd0);
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_halt", 32'(halt), 32'd0);
      rst = 1'b0;
      #1 chk("idle_req", 32'(inst_req_valid), 32'd0);
      @(negedge clk);
   endtask

   task automatic chk_halt(input logic [31:0] code, input logic illegal_v);
      chk("halt", 32'(halt), 32'd1);
      chk("halt_illegal", 32'(halt_illegal), 32'(illegal_v));
      chk("halt_code", halt_code, code);
      chk("halt_req", 32'(inst_req_valid), 32'd0);
   endtask

   initial begin
      int c0;
      rst = 1'b1; inst_resp_valid = 1'b0; inst = '0;
      inst_resp_valid_e = 1'b0; inst_e = '0;
      repeat (2) @(negedge clk);
      chk("reset_req", 32'(inst_req_valid), 32'd0);
      chk("reset_commit", 32'(commit_valid), 32'd0);
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_halt_illegal", 32'(halt_illegal), 32'd0);
      chk("reset_halt_code", halt_code, 32'd0);
      chk("reset_pc", pc, 32'h8000_0000);
      rst = 1'b0;
      #1 chk("idle_req", 32'(inst_req_valid), 32'd0);
      @(negedge clk);

      // Arithmetic chain; result lands in a0 and is exposed by ebreak.
      issue(32'h0050_0093, 32'h8000_0000, 0, 1);  // addi x1,x0,5
      issue(32'hFFD0_8113, 32'h8000_0004, 0, 1);  // addi x2,x1,-3
      issue(32'h4011_01B3, 32'h8000_0008, 0, 1);  // sub  x3,x2,x1
      issue(32'h1234_5237, 32'h8000_000C, 0, 1);  // lui  x4,0x12345
      issue(32'h0041_8533, 32'h8000_0010, 0, 1);  // add  x10,x3,x4
      issue(32'h0000_1297, 32'h8000_0014, 0, 1);  // auipc x5,1
      issue(32'h0055_0533, 32'h8000_0018, 0, 1);  // add  x10,x10,x5
      issue(32'h0010_0073, 32'h8000_001C, 0, 0);  // ebreak
      @(negedge clk);
      chk_halt(32'h9234_6011, 1'b0);
      inst_resp_valid = 1'b1; inst = 32'h0050_0093;
      repeat (3) begin
         @(negedge clk);
         chk("halt_sticky", 32'(halt), 32'd1);
         chk("halt_no_req", 32'(inst_req_valid), 32'd0);
      end
      inst_resp_valid = 1'b0;

      // Jumps, link with rd==rs1, jalr lsb clear, negative jal offset.
      pulse_reset();
      issue(32'h0080_00EF, 32'h8000_0000, 0, 1);  // jal  x1,8
      issue(32'h0000_80E7, 32'h8000_0008, 0, 1);  // jalr x1,0(x1)
      issue(32'h02A0_0513, 32'h8000_0004, 0, 1);  // addi x10,x0,42
      issue(32'h0010_8067, 32'h8000_0008, 0, 1);  // jalr x0,1(x1)
      issue(32'hFF5F_F06F, 32'h8000_000C, 0, 1);  // jal  x0,-12
      issue(32'h0010_0073, 32'h8000_0000, 0, 0);  // ebreak
      @(negedge clk);
      chk_halt(32'h0000_002A, 1'b0);

      // Unsupported encoding halts without touching PC.
      pulse_reset();
      issue(32'h0070_0513, 32'h8000_0000, 0, 1);  // addi x10,x0,7
      issue(32'hFFFF_FFFF, 32'h8000_0004, 0, 0);
      @(negedge clk);
      chk_halt(32'h0000_0007, 1'b1);
      chk("illegal_pc", pc, 32'h8000_0004);

      // Reset mid-FETCH with a response on the same cycle and during IDLE.
      pulse_reset();
      repeat (2) @(negedge clk);
      chk("pre_rst_req", 32'(inst_req_valid), 32'd1);
      rst = 1'b1; inst_resp_valid = 1'b1; inst = 32'h0770_0513;
      @(negedge clk);
      chk("midfetch_rst_req", 32'(inst_req_valid), 32'd0);
      chk("midfetch_rst_pc", pc, 32'h8000_0000);
      chk("midfetch_rst_halt", 32'(halt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      inst_resp_valid = 1'b0;
      c0 = n_commits;
      issue(32'h0010_0513, 32'h8000_0000, 3, 1);  // addi x10,x0,1, response 3 cycles late
      issue(32'h0010_0073, 32'h8000_0004, 0, 0);  // ebreak
      @(negedge clk);
      chk_halt(32'h0000_0001, 1'b0);
      chk("one_commit", 32'(n_commits - c0), 32'd1);

      // RV32E instance: x17 is out of range.
      chk("e_req", 32'(inst_req_valid_e), 32'd1);
      inst_resp_valid_e = 1'b1; inst_e = 32'h0050_0893;  // addi x17,x0,5
      @(negedge clk);
      inst_resp_valid_e = 1'b0;
      chk("e_no_commit", 32'(commit_valid_e), 32'd0);
      @(negedge clk);
      chk("e_halt", 32'(halt_e), 32'd1);
      chk("e_halt_illegal", 32'(halt_illegal_e), 32'd1);
      chk("e_pc", pc_e, 32'h8000_0000);
      chk("e_req_off", 32'(inst_req_valid_e), 32'd0);
      chk("e_commit_pc", commit_pc_e, pc_e);
      chk("e_halt_code_known", 32'($isunknown(halt_code_e)), 32'd0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
